alu_ascii_stream: RTL and testbench
===================================

Name: alu_ascii_stream

Overview:
- Byte-serial, parametrised successor to the combinational ASCII ALU interface.
- Accepts an ASCII expression one character per handshake, e.g. "12+34=": hex operand A, operator, hex operand B, '='.
- Computes a W-bit unsigned result and streams it back as W/4 uppercase hex ASCII characters, followed by a terminator character.
- Sits between the keyboard/UART character source and the display/UART character sink.

Parameters:
- W, 16, operand/result width in bits. Must be a multiple of 4, range 4..32.
- TERM_CHAR, 8'h2E ('.'), terminator appended after every response.

Ports:
- clk  input  1  system clock
- rst  input  1  reset: synchronous, active-high
- in_char  input  8  ASCII character in
- in_valid  input  1  in_char valid
- in_ready  output  1  block accepts in_char this cycle
- out_char  output  8  ASCII character out
- out_valid  output  1  out_char valid
- out_ready  input  1  sink accepts out_char
- busy  output  1  high in COMPUTE, EMIT and ERR_EMIT
- err  output  1  one-cycle pulse when an expression is rejected

Behaviour:
- Reset: all of the following take effect on the first clk edge with rst=1.
  - state=GET_A; A, B, digit counters and op cleared.
  - in_ready=1, out_valid=0, out_char=8'h00, busy=0, err=0.
  - rst overrides any state, including mid-EMIT. A partially sent response is abandoned and nothing further is emitted.
- A character transfers when in_valid&&in_ready. An output character transfers when out_valid&&out_ready.
- Hex digits: '0'-'9', 'A'-'F', 'a'-'f'. Shift value left 4 and OR in the nibble. Space (8'h20) is ignored in GET_A and GET_B.
- GET_A:
  - Hex digit: accumulate into A.
  - One of '+', '-', '&', '|', '^' with at least one A digit: latch op, go to GET_B.
  - 'N' with at least one A digit: latch NOT, go to GET_N.
  - Anything else, more than W/4 digits, or an operator with zero digits: error.
- GET_B:
  - Hex digit: accumulate into B.
  - '=' with at least one B digit: go to COMPUTE.
  - Anything else, more than W/4 digits, or '=' with zero digits: error.
- GET_N:
  - '=': go to COMPUTE. Any other non-space character: error.
- COMPUTE (one cycle, in_ready=0): R = A+B, A-B, A&B, A|B, A^B or ~A, truncated to W bits. Wrap-around is silent; subtraction is two's complement. Then go to EMIT.
- EMIT:
  - out_valid=1. Sends W/4 hex digits of R, MSB nibble first, uppercase, then TERM_CHAR.
  - out_char is held stable while out_valid && !out_ready.
  - After TERM_CHAR transfers: clear A, B and counters; state=GET_A on the next cycle.
- Latency: '=' accepted at cycle t, COMPUTE at t+1, first out_valid at t+2.
- Error handling:
  - err pulses in the cycle after the offending character is accepted.
  - If the offending character is '=', go to ERR_EMIT. Otherwise go to FLUSH.
  - FLUSH: in_ready=1; discard characters until '=' is accepted, then go to ERR_EMIT.
  - ERR_EMIT: emits 'E' then TERM_CHAR under the same handshake rules, then returns to GET_A.
- in_ready is 0 in COMPUTE, EMIT and ERR_EMIT. Input is never accepted while a response is pending.
- in_valid with in_ready=0 has no effect; the source must hold the character.

Decomposition:
- Package alu_ascii_pkg:
  - State enum: GET_A, GET_B, GET_N, COMPUTE, EMIT, FLUSH, ERR_EMIT.
  - Op enum: ADD, SUB, AND, OR, XOR, NOT.
  - Character constants: '=', '+', '-', '&', '|', '^', 'N', 'E', space.
- Sub-module ascii_hex_codec (combinational):
  - char→{is_hex, nibble}.
  - nibble→uppercase char.
  - Instantiated once for decode and once for encode.

Test Plan (W=16, out_ready=1 unless stated):
- "12+34=" → "0046." then in_ready=1. First out_valid exactly 2 cycles after '=' accepted.
- "FFFF+1=" → "0000." (wrap). "5-7=" → "FFFE.". "F0F0^0FF0=" → "FF00.".
- "A5N=" → "FF5A.". "A5N3=" → err pulse, then "E." after '=' is flushed.
- "1G+2=" → err one cycle after 'G'; "+2" discarded; "E." emitted. "12345+1=" (5 digits) → "E.". "+3=" and "3+=" → "E.".
- "12+34=" with out_ready toggling 1/0 each cycle → out_char stable while stalled; sequence still "0046."; in_ready=0 throughout.
- Assert rst during EMIT after the '0','0' transfers → next cycle out_valid=0, in_ready=1; a fresh "1+1=" → "0002.".

Source files
------------

// File: rtl/alu_ascii_pkg.sv
// Shared types and character constants for the byte-serial ASCII ALU.
// Contents:
//   state_t     - controller states
//   op_t        - operations latched from the expression
//   CH_*        - ASCII codes recognised by the parser
//   is_binop()  - true for the two-operand operator characters
//   binop_of()  - maps an operator character to its op_t
package alu_ascii_pkg;

    typedef enum logic [2:0] {
        GET_A,
        GET_B,
        GET_N,
        COMPUTE,
        EMIT,
        FLUSH,
        ERR_EMIT
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD,
        OP_SUB,
        OP_AND,
        OP_OR,
        OP_XOR,
        OP_NOT
    } op_t;

    localparam logic [7:0] CH_EQ    = 8'h3D;
    localparam logic [7:0] CH_PLUS  = 8'h2B;
    localparam logic [7:0] CH_MINUS = 8'h2D;
    localparam logic [7:0] CH_AMP   = 8'h26;
    localparam logic [7:0] CH_PIPE  = 8'h7C;
    localparam logic [7:0] CH_CARET = 8'h5E;
    localparam logic [7:0] CH_N     = 8'h4E;
    localparam logic [7:0] CH_E     = 8'h45;
    localparam logic [7:0] CH_SPACE = 8'h20;

    function automatic logic is_binop(input logic [7:0] c);
        return (c == CH_PLUS) || (c == CH_MINUS) || (c == CH_AMP) ||
               (c == CH_PIPE) || (c == CH_CARET);
    endfunction

    function automatic op_t binop_of(input logic [7:0] c);
        case (c)
            CH_MINUS: return OP_SUB;
            CH_AMP:   return OP_AND;
            CH_PIPE:  return OP_OR;
            CH_CARET: return OP_XOR;
            default:  return OP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/alu_ascii_stream_codec.sv
// Combinational ASCII <-> hex nibble converter.
// Ports:
//   char_in    - ASCII character to decode
//   is_hex     - char_in is 0-9, A-F or a-f
//   nibble_out - value of char_in when is_hex, else 0
//   nibble_in  - nibble to encode
//   char_out   - uppercase ASCII hex digit for nibble_in
module ascii_hex_codec
    import alu_ascii_pkg::*;
(
    input  logic [7:0] char_in,
    output logic       is_hex,
    output logic [3:0] nibble_out,
    input  logic [3:0] nibble_in,
    output logic [7:0] char_out
);

    // Letters carry their value minus 9 in the low nibble ('A' = 8'h41).
    always_comb begin
        is_hex     = 1'b0;
        nibble_out = 4'h0;
        if (char_in >= 8'h30 && char_in <= 8'h39) begin
            is_hex     = 1'b1;
            nibble_out = char_in[3:0];
        end else if ((char_in >= 8'h41 && char_in <= 8'h46) ||
                     (char_in >= 8'h61 && char_in <= 8'h66)) begin
            is_hex     = 1'b1;
            nibble_out = char_in[3:0] + 4'd9;
        end
    end

    always_comb begin
        if (nibble_in < 4'd10) begin
            char_out = 8'h30 + {4'h0, nibble_in};
        end else begin
            char_out = 8'h37 + {4'h0, nibble_in};
        end
    end

endmodule

// File: rtl/alu_ascii_stream.sv
// Byte-serial ASCII ALU: parses "<hexA><op><hexB>=" or "<hexA>N=" one
// character per handshake, computes a W-bit result and streams it back as
// W/4 uppercase hex digits followed by TERM_CHAR. Malformed expressions are
// answered with "E" + TERM_CHAR once their '=' has been consumed.
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   in_char/valid/ready  - character input handshake
//   out_char/valid/ready - character output handshake
//   busy                 - computing or emitting a response
//   err                  - one-cycle pulse when an expression is rejected
module alu_ascii_stream
    import alu_ascii_pkg::*;
#(
    parameter int         W         = 16,
    parameter logic [7:0] TERM_CHAR = 8'h2E
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_char,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_char,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       err
);

    localparam int NDIG  = W / 4;
    localparam int CNT_W = $clog2(NDIG + 2);
    localparam logic [CNT_W-1:0] NDIG_C = CNT_W'(NDIG);

    state_t           state_q, state_n;
    op_t              op_q, op_n;
    logic [W-1:0]     a_q, a_n, b_q, b_n, r_q, r_n;
    logic [CNT_W-1:0] a_cnt_q, a_cnt_n, b_cnt_q, b_cnt_n, idx_q, idx_n;
    logic             err_q, err_n;
    logic             accept, reject, finish;

    logic             in_is_hex;
    logic [3:0]       in_nibble;
    logic [7:0]       digit_char;
    logic [7:0]       unused_dec_char;
    logic             unused_enc_is_hex;
    logic [3:0]       unused_enc_nibble;

    ascii_hex_codec u_decode (
        .char_in    (in_char),
        .is_hex     (in_is_hex),
        .nibble_out (in_nibble),
        .nibble_in  (4'h0),
        .char_out   (unused_dec_char)
    );

    // The result is shifted left after each digit, so the digit to send is
    // always the top nibble.
    ascii_hex_codec u_encode (
        .char_in    (8'h00),
        .is_hex     (unused_enc_is_hex),
        .nibble_out (unused_enc_nibble),
        .nibble_in  (r_q[W-1 -: 4]),
        .char_out   (digit_char)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= GET_A;
            op_q    <= OP_ADD;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            a_cnt_q <= '0;
            b_cnt_q <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            op_q    <= op_n;
            a_q     <= a_n;
            b_q     <= b_n;
            r_q     <= r_n;
            a_cnt_q <= a_cnt_n;
            b_cnt_q <= b_cnt_n;
            idx_q   <= idx_n;
            err_q   <= err_n;
        end
    end

    assign err = err_q;

    // idx_q counts digits already sent; idx_q == NDIG means the terminator
    // is on the bus. In ERR_EMIT it selects 'E' (0) or the terminator (1).
    always_comb begin
        state_n = state_q;
        op_n    = op_q;
        a_n     = a_q;
        b_n     = b_q;
        r_n     = r_q;
        a_cnt_n = a_cnt_q;
        b_cnt_n = b_cnt_q;
        idx_n   = idx_q;
        err_n   = 1'b0;
        reject  = 1'b0;
        finish  = 1'b0;

        in_ready  = (state_q == GET_A) || (state_q == GET_B) ||
                    (state_q == GET_N) || (state_q == FLUSH);
        busy      = (state_q == COMPUTE) || (state_q == EMIT) ||
                    (state_q == ERR_EMIT);
        out_valid = 1'b0;
        out_char  = 8'h00;
        accept    = in_valid && in_ready;

        case (state_q)
            GET_A: begin
                if (accept && in_char != CH_SPACE) begin
                    if (in_is_hex) begin
                        if (a_cnt_q == NDIG_C) begin
                            reject = 1'b1;
                        end else begin
                            a_n     = (a_q << 4) | W'(in_nibble);
                            a_cnt_n = a_cnt_q + CNT_W'(1);
                        end
                    end else if (is_binop(in_char) && a_cnt_q != '0) begin
                        op_n    = binop_of(in_char);
                        state_n = GET_B;
                    end else if (in_char == CH_N && a_cnt_q != '0) begin
                        op_n    = OP_NOT;
                        state_n = GET_N;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            GET_B: begin
                if (accept && in_char != CH_SPACE) begin
                    if (in_is_hex) begin
                        if (b_cnt_q == NDIG_C) begin
                            reject = 1'b1;
                        end else begin
                            b_n     = (b_q << 4) | W'(in_nibble);
                            b_cnt_n = b_cnt_q + CNT_W'(1);
                        end
                    end else if (in_char == CH_EQ && b_cnt_q != '0) begin
                        state_n = COMPUTE;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            GET_N: begin
                if (accept && in_char != CH_SPACE) begin
                    if (in_char == CH_EQ) begin
                        state_n = COMPUTE;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            COMPUTE: begin
                case (op_q)
                    OP_ADD:  r_n = a_q + b_q;
                    OP_SUB:  r_n = a_q - b_q;
                    OP_AND:  r_n = a_q & b_q;
                    OP_OR:   r_n = a_q | b_q;
                    OP_XOR:  r_n = a_q ^ b_q;
                    OP_NOT:  r_n = ~a_q;
                    default: r_n = '0;
                endcase
                idx_n   = '0;
                state_n = EMIT;
            end
            EMIT: begin
                out_valid = 1'b1;
                out_char  = (idx_q == NDIG_C) ? TERM_CHAR : digit_char;
                if (out_ready) begin
                    if (idx_q == NDIG_C) begin
                        finish = 1'b1;
                    end else begin
                        r_n   = r_q << 4;
                        idx_n = idx_q + CNT_W'(1);
                    end
                end
            end
            FLUSH: begin
                if (accept && in_char == CH_EQ) begin
                    idx_n   = '0;
                    state_n = ERR_EMIT;
                end
            end
            ERR_EMIT: begin
                out_valid = 1'b1;
                out_char  = (idx_q == '0) ? CH_E : TERM_CHAR;
                if (out_ready) begin
                    if (idx_q == '0) begin
                        idx_n = CNT_W'(1);
                    end else begin
                        finish = 1'b1;
                    end
                end
            end
            default: state_n = GET_A;
        endcase

        // A rejected '=' already ends the expression, so there is nothing
        // left to flush.
        if (reject) begin
            err_n   = 1'b1;
            idx_n   = '0;
            state_n = (in_char == CH_EQ) ? ERR_EMIT : FLUSH;
        end

        if (finish) begin
            a_n     = '0;
            b_n     = '0;
            a_cnt_n = '0;
            b_cnt_n = '0;
            op_n    = OP_ADD;
            idx_n   = '0;
            state_n = GET_A;
        end
    end

endmodule

// File: tb/tb_alu_ascii_stream.sv
// Self-checking bench for alu_ascii_stream (W=16, TERM_CHAR='.').
// Directed expressions push their hand-computed responses into a scoreboard
// queue; an independent monitor pops and compares every output transfer.
module tb_alu_ascii_stream;

    logic       clk;
    logic       rst;
    logic [7:0] in_char;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_char;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       err;

    byte        sb[$];
    int         vectors     = 0;
    int         miscompares = 0;
    int         xfer_count  = 0;
    int         err_count   = 0;
    bit         toggle_mode = 0;

    alu_ascii_stream #(
        .W         (16),
        .TERM_CHAR (8'h2E)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_char   (in_char),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_char  (out_char),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .err       (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Output monitor: samples on the falling edge, between active edges.
    initial begin
        bit  held;
        byte held_char;
        byte exp_c;
        held = 0;
        held_char = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held = 0;
            end else begin
                if (err) err_count++;
                if (out_valid) check("in_ready_low_while_responding", in_ready, 0);
                if (held) begin
                    check("stall_valid_held", out_valid, 1);
                    if (out_valid) check("stall_char_stable", out_char, held_char);
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("[TB] FAIL unexpected_out_char: got %0h, expected nothing", out_char);
                    end else begin
                        exp_c = sb.pop_front();
                        check("out_char", out_char, exp_c);
                    end
                    xfer_count++;
                end
                held = out_valid && !out_ready;
                held_char = out_char;
            end
        end
    end

    // Sink back-pressure pattern: toggles out_ready every cycle when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (toggle_mode) out_ready = ~out_ready;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic sendChar(input logic [7:0] c);
        int guard;
        guard = 0;
        in_char  = c;
        in_valid = 1'b1;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            check("in_ready_timeout", in_ready, 1);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // bad_idx: index of the character whose acceptance must pulse err (-1: none).
    task automatic applyStimulus(input string expr, input string resp, input int bad_idx);
        for (int i = 0; i < resp.len(); i++) sb.push_back(resp[i]);
        for (int i = 0; i < expr.len(); i++) begin
            sendChar(expr[i]);
            check($sformatf("err_after_%s[%0d]", expr, i), err, (i == bad_idx) ? 1 : 0);
            if (bad_idx < 0 && i == expr.len() - 1) begin
                check("compute_no_out_valid", out_valid, 0);
                check("compute_busy", busy, 1);
                check("compute_in_ready_low", in_ready, 0);
                @(negedge clk);
                check("first_out_valid_latency", out_valid, 1);
            end
        end
    endtask

    task automatic checkOutput(input string name, input int exp_errs, input int err_base);
        int guard;
        guard = 0;
        while ((sb.size() != 0 || !in_ready) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check({name, "_response_complete"}, sb.size(), 0);
        check({name, "_in_ready_after"}, in_ready, 1);
        check({name, "_busy_after"}, busy, 0);
        check({name, "_err_pulses"}, err_count - err_base, exp_errs);
    endtask

    initial begin
        int base;
        int guard;

        rst       = 1'b1;
        in_char   = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_char", out_char, 8'h00);
        check("reset_busy", busy, 0);
        check("reset_err", err, 0);
        rst = 1'b0;

        base = err_count; applyStimulus("12+34=", "0046.", -1);      checkOutput("add", 0, base);
        base = err_count; applyStimulus("FFFF+1=", "0000.", -1);     checkOutput("wrap", 0, base);
        base = err_count; applyStimulus("5-7=", "FFFE.", -1);        checkOutput("sub", 0, base);
        base = err_count; applyStimulus("F0F0^0FF0=", "FF00.", -1);  checkOutput("xor", 0, base);
        base = err_count; applyStimulus("a5 & 3c=", "0024.", -1);    checkOutput("and_lower_space", 0, base);
        base = err_count; applyStimulus("1200|0034=", "1234.", -1);  checkOutput("or", 0, base);
        base = err_count; applyStimulus("A5N=", "FF5A.", -1);        checkOutput("not", 0, base);
        base = err_count; applyStimulus("A5N3=", "E.", 3);           checkOutput("not_extra", 1, base);
        base = err_count; applyStimulus("1G+2=", "E.", 1);           checkOutput("bad_char", 1, base);
        base = err_count; applyStimulus("12345+1=", "E.", 4);        checkOutput("too_many_a", 1, base);
        base = err_count; applyStimulus("1+12345=", "E.", 6);        checkOutput("too_many_b", 1, base);
        base = err_count; applyStimulus("+3=", "E.", 0);             checkOutput("no_a", 1, base);
        base = err_count; applyStimulus("3+=", "E.", 2);             checkOutput("no_b", 1, base);

        toggle_mode = 1;
        base = err_count; applyStimulus("12+34=", "0046.", -1);      checkOutput("stall", 0, base);
        toggle_mode = 0;
        @(negedge clk);
        out_ready = 1'b1;

        // Reset in the middle of a response, after two digits have gone out.
        base = xfer_count;
        applyStimulus("12+34=", "0046.", -1);
        guard = 0;
        while (xfer_count < base + 2 && guard < 200) begin
            @(posedge clk);
            #2;
            guard++;
        end
        check("mid_emit_two_transfers", xfer_count - base, 2);
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        check("mid_emit_reset_out_valid", out_valid, 0);
        check("mid_emit_reset_in_ready", in_ready, 1);
        check("mid_emit_reset_out_char", out_char, 8'h00);
        check("mid_emit_reset_busy", busy, 0);
        rst = 1'b0;
        base = err_count; applyStimulus("1+1=", "0002.", -1);        checkOutput("after_reset", 0, base);

        repeat (3) @(negedge clk);
        check("idle_out_valid", out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
